ps2_rx_ctrl: RTL and testbench

Synchronous PS/2 keyboard receive controller. It samples the keyboard clock and data lines in the system clock domain, validates each 11-bit frame (start, parity, stop), and strips E0/F0 prefix bytes. Each complete key event is emitted as one code with make/break and extended flags over a valid/ready handshake. It sits between the keyboard pins and the display/decode logic, replacing edge-clocked capture with a single-clock, checked front end.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_edge_sync.sv | 47 ++++
 rtl/ps2_rx_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ps2_rx_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_event_t;

    // True for bytes that only modify the next key event instead of forming one.
    function automatic logic isPrefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Synchronizes the raw PS/2 clock and data lines and produces a registered
// falling-edge strobe on kbclk together with the data level sampled with it.
module ps2_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic kbclk_i,
    input  logic kbdata_i,
    output logic fall_o,
    output logic data_o
);

    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [SYNC_STAGES-1:0] dataSync_q;
    logic                   clkPrev_q;
    logic                   fall_q;
    logic                   data_q;

    // Shift each raw line through its synchronizer chain; the clock chain resets low so a line held low at release cannot look like a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkSync_q  <= '0;
            dataSync_q <= '1;
        end else begin
            clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], kbclk_i};
            dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], kbdata_i};
        end
    end

    // Remember the previous synchronized clock level and register the falling-edge strobe with the data level it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkPrev_q <= 1'b0;
            fall_q    <= 1'b0;
            data_q    <= 1'b1;
        end else begin
            clkPrev_q <= clkSync_q[SYNC_STAGES-1];
            fall_q    <= clkPrev_q & ~clkSync_q[SYNC_STAGES-1];
            data_q    <= dataSync_q[SYNC_STAGES-1];
        end
    end

    assign fall_o = fall_q;
    assign data_o = data_q;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: frame checking, timeout, E0/F0 prefix
// stripping and a valid/ready event register, all in the system clock domain.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbclk,
    input  logic       kbdata,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       err,
    output logic       ovf
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic             fall;
    logic             rxData;

    frame_state_e     state_q, state_d;
    logic [2:0]       bitCnt_q;
    logic [7:0]       shift_q;
    logic             parErr_q;
    logic [TMO_W-1:0] tmoCnt_q;
    logic             tmoHit;

    logic             startEn;
    logic             shiftEn;
    logic             parityEn;
    logic             byteGood;
    logic             frameErr;

    logic             pendExt_q;
    logic             pendBrk_q;
    logic             newEvent;
    ps2_event_t       newEv;
    ps2_event_t       ev_q;
    logic             evValid_q;
    logic             err_q;
    logic             ovf_q;

    ps2_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .kbclk_i (kbclk),
        .kbdata_i(kbdata),
        .fall_o  (fall),
        .data_o  (rxData)
    );

    // The abort fires one cycle early on the counter's next value so that err and the return to IDLE land exactly when the count reaches its limit.
    assign tmoHit = (state_q != IDLE) && !fall &&
                    (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES - 2));

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next frame state: advance only on a kbclk falling edge, abort to IDLE on timeout.
    always_comb begin
        state_d = state_q;
        if (tmoHit) begin
            state_d = IDLE;
        end else if (fall) begin
            unique case (state_q)
                IDLE:    if (!rxData) state_d = DATA;
                DATA:    if (bitCnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Per-state strobes driving the datapath, the good-byte path and the error pulse.
    always_comb begin
        startEn  = 1'b0;
        shiftEn  = 1'b0;
        parityEn = 1'b0;
        byteGood = 1'b0;
        frameErr = 1'b0;
        if (fall) begin
            unique case (state_q)
                IDLE:   startEn  = !rxData;
                DATA:   shiftEn  = 1'b1;
                PARITY: parityEn = 1'b1;
                STOP: begin
                    if (rxData && !parErr_q) byteGood = 1'b1;
                    else                     frameErr = 1'b1;
                end
                default: frameErr = 1'b0;
            endcase
        end
        if (tmoHit) frameErr = 1'b1;
    end

    // Frame datapath: bit counter, LSB-first shift register and the odd-parity verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitCnt_q <= 3'd0;
            shift_q  <= 8'h00;
            parErr_q <= 1'b0;
        end else begin
            if (startEn) begin
                bitCnt_q <= 3'd0;
                parErr_q <= 1'b0;
            end
            if (shiftEn) begin
                shift_q  <= {rxData, shift_q[7:1]};
                bitCnt_q <= bitCnt_q + 3'd1;
            end
            if (parityEn) begin
                parErr_q <= ~(^shift_q ^ rxData);
            end
        end
    end

    // Inter-edge idle counter; it only runs while a frame is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmoCnt_q <= '0;
        end else if (fall) begin
            tmoCnt_q <= '0;
        end else if (state_q != IDLE) begin
            tmoCnt_q <= tmoCnt_q + TMO_W'(1);
        end
    end

    // A good non-prefix byte becomes an event carrying the pending prefix flags.
    always_comb begin
        newEv.code = shift_q;
        newEv.ext  = pendExt_q;
        newEv.brk  = pendBrk_q;
        newEvent   = byteGood && !isPrefix(shift_q);
    end

    // Prefix flags: set by E0/F0, consumed by the next key byte, wiped by any error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendExt_q <= 1'b0;
            pendBrk_q <= 1'b0;
        end else if (frameErr) begin
            pendExt_q <= 1'b0;
            pendBrk_q <= 1'b0;
        end else if (byteGood) begin
            if (shift_q == PS2_EXT) begin
                pendExt_q <= 1'b1;
            end else if (shift_q == PS2_BRK) begin
                pendBrk_q <= 1'b1;
            end else begin
                pendExt_q <= 1'b0;
                pendBrk_q <= 1'b0;
            end
        end
    end

    // Output event register with valid/ready handshake; a stalled consumer keeps the old event and the new one is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q      <= '0;
            evValid_q <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            err_q <= frameErr;
            ovf_q <= newEvent && evValid_q && !ev_ready;
            if (newEvent && (!evValid_q || ev_ready)) begin
                ev_q      <= newEv;
                evValid_q <= 1'b1;
            end else if (evValid_q && ev_ready) begin
                evValid_q <= 1'b0;
            end
        end
    end

    assign ev_code  = ev_q.code;
    assign ev_ext   = ev_q.ext;
    assign ev_brk   = ev_q.brk;
    assign ev_valid = evValid_q;
    assign err      = err_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: directed frames plus a randomized
// frame stream compared against a frame-level prefix/event model.
module tb_ps2_rx_ctrl;

    localparam int TMO  = 200;
    localparam int SYNC = 2;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       kbclk;
    logic       kbdata;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       ev_valid;
    logic       ev_ready;
    logic       err;
    logic       ovf;

    int assertCount = 0;
    int failCount   = 0;
    int errSeen     = 0;
    int ovfSeen     = 0;
    logic [9:0] evQ[$];

    ps2_rx_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .kbclk   (kbclk),
        .kbdata  (kbdata),
        .ev_code (ev_code),
        .ev_ext  (ev_ext),
        .ev_brk  (ev_brk),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .err     (err),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Record accepted events and count cycles with err/ovf high.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ev_valid && ev_ready) evQ.push_back({ev_code, ev_ext, ev_brk});
            if (err) errSeen++;
            if (ovf) ovfSeen++;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed no end, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive nFalls bits of an 11-bit frame (start, 8 data LSB first, odd parity, stop).
    task automatic applyStimulus(input logic [7:0] b, input bit badPar, input int nFalls);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < nFalls; i++) begin
            kbdata = bits[i];
            repeat (HALF) @(negedge clk);
            kbclk = 1'b0;
            repeat (HALF) @(negedge clk);
            kbclk = 1'b1;
        end
        kbdata = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic setReady(input logic v);
        @(posedge clk);
        #1;
        ev_ready = v;
    endtask

    task automatic expectEvent(input string tag, input logic [7:0] code,
                               input logic ext, input logic brk);
        logic [9:0] got;
        checkOutput({tag, "_count"}, evQ.size(), 1);
        got = (evQ.size() > 0) ? evQ.pop_front() : 10'h3FF;
        checkOutput({tag, "_event"}, {22'd0, got}, {22'd0, code, ext, brk});
        evQ.delete();
    endtask

    initial begin
        int e0;
        int o0;
        logic [10:0] pbits;
        logic [7:0]  b;
        int kind;
        bit bad;
        bit pE;
        bit pB;
        int errExp;
        logic [9:0] expQ[$];

        rst      = 1'b1;
        kbclk    = 1'b1;
        kbdata   = 1'b1;
        ev_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_code", ev_code, 0);
        checkOutput("rst_flags", {ev_ext, ev_brk, ev_valid, err, ovf}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] plain make code");
        e0 = errSeen;
        applyStimulus(8'h1C, 1'b0, 11);
        expectEvent("make_1C", 8'h1C, 1'b0, 1'b0);
        checkOutput("make_no_err", errSeen - e0, 0);

        $display("[TB] break prefix");
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h1C, 1'b0, 11);
        expectEvent("break_1C", 8'h1C, 1'b0, 1'b1);

        $display("[TB] extended break then plain");
        applyStimulus(8'hE0, 1'b0, 11);
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h75, 1'b0, 11);
        expectEvent("ext_brk_75", 8'h75, 1'b1, 1'b1);
        applyStimulus(8'h1C, 1'b0, 11);
        expectEvent("after_ext_1C", 8'h1C, 1'b0, 1'b0);

        $display("[TB] parity errors");
        e0 = errSeen;
        applyStimulus(8'h1C, 1'b1, 11);
        checkOutput("par_err_pulse", errSeen - e0, 1);
        checkOutput("par_no_event", evQ.size(), 0);
        e0 = errSeen;
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h1C, 1'b1, 11);
        applyStimulus(8'h1C, 1'b0, 11);
        expectEvent("err_clears_brk", 8'h1C, 1'b0, 1'b0);
        checkOutput("err_clears_brk_err", errSeen - e0, 1);

        $display("[TB] timeout");
        e0 = errSeen;
        pbits = {1'b1, 1'b0, 8'hA5, 1'b0};
        for (int i = 0; i < 4; i++) begin
            kbdata = pbits[i];
            repeat (HALF) @(negedge clk);
            kbclk = 1'b0;
            if (i < 3) begin
                repeat (HALF) @(negedge clk);
                kbclk = 1'b1;
            end
        end
        for (int k = 1; k <= SYNC + TMO + 3; k++) begin
            @(negedge clk);
            if (k == SYNC + TMO)     checkOutput("tmo_before", err, 0);
            if (k == SYNC + TMO + 1) checkOutput("tmo_at", err, 1);
            if (k == SYNC + TMO + 2) checkOutput("tmo_after", err, 0);
            if (k == HALF) begin
                kbclk  = 1'b1;
                kbdata = 1'b1;
            end
        end
        checkOutput("tmo_single_err", errSeen - e0, 1);
        applyStimulus(8'h1C, 1'b0, 11);
        expectEvent("tmo_recover", 8'h1C, 1'b0, 1'b0);

        $display("[TB] overflow with stalled consumer");
        setReady(1'b0);
        o0 = ovfSeen;
        applyStimulus(8'h1C, 1'b0, 11);
        applyStimulus(8'h32, 1'b0, 11);
        @(negedge clk);
        checkOutput("ovf_valid", ev_valid, 1);
        checkOutput("ovf_code_held", ev_code, 8'h1C);
        checkOutput("ovf_flags_held", {ev_ext, ev_brk}, 0);
        checkOutput("ovf_pulse", ovfSeen - o0, 1);
        setReady(1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("drain_valid", ev_valid, 0);
        expectEvent("drain", 8'h1C, 1'b0, 1'b0);

        $display("[TB] reset mid-frame and mid-handshake");
        setReady(1'b0);
        applyStimulus(8'h1C, 1'b0, 11);
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h00, 1'b0, 5);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_code", ev_code, 0);
        checkOutput("mid_rst_flags", {ev_ext, ev_brk, ev_valid, err, ovf}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        setReady(1'b1);
        evQ.delete();
        applyStimulus(8'h1C, 1'b0, 11);
        expectEvent("post_rst", 8'h1C, 1'b0, 1'b0);

        $display("[TB] randomized frame stream");
        pE = 1'b0;
        pB = 1'b0;
        errExp = 0;
        e0 = errSeen;
        evQ.delete();
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 9);
            b    = 8'($urandom_range(0, 255));
            if (kind == 6) b = 8'hE0;
            if (kind == 7) b = 8'hF0;
            bad = (kind == 8);
            applyStimulus(b, bad, 11);
            if (bad) begin
                pE = 1'b0;
                pB = 1'b0;
                errExp++;
            end else if (b == 8'hE0) begin
                pE = 1'b1;
            end else if (b == 8'hF0) begin
                pB = 1'b1;
            end else begin
                expQ.push_back({b, pE, pB});
                pE = 1'b0;
                pB = 1'b0;
            end
        end
        checkOutput("rand_count", evQ.size(), expQ.size());
        checkOutput("rand_errs", errSeen - e0, errExp);
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput("rand_event", (i < evQ.size()) ? {22'd0, evQ[i]} : 32'hFFFF_FFFF,
                        {22'd0, expQ[i]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
